// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter.
//   arb_state_t : sequencer states (IDLE, START, WAIT, DONE)
//   BCD_DIGIT_W : width of one BCD digit
//   BIN_W       : width of the converted binary result (0..99 fits in 7 bits)
//   BCD_MAX     : largest legal BCD digit value
//   digit_ok()  : true when a digit is a legal BCD value
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W       = 7;
  localparam int BCD_MAX     = 9;

  function automatic logic digit_ok(input logic [BCD_DIGIT_W-1:0] d);
    return (int'(d) <= BCD_MAX);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector. Picks the first set request
// bit at or after ptr, wrapping around to bit 0.
// Ports:
//   req   in  N_REQ : request vector
//   ptr   in  IDX_W : highest-priority position for this pick
//   grant out N_REQ : one-hot winner (zero when req is zero)
//   idx   out IDX_W : binary index of the winner
//   valid out 1     : at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pick_src;

  // Requests at or above ptr win first; if none are set, fall back to the
  // full vector, which gives the wrap-around to the lowest index.
  always_comb begin
    upper = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = (i >= int'(ptr));
    end
    masked   = req & upper;
    pick_src = (masked != '0) ? masked : req;
    grant    = '0;
    idx      = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-digit BCD-to-binary converter
// among N_REQ requesters. A winner's digits are latched and handed to the
// converter; the converter's result is written to that requester's result
// register together with a one-cycle done pulse.
// Optional feature: define BCD_ARB_RANGE_CHECK_EN to reject digits above 9
// without starting the converter (sets the requester's sticky err flag).
// Ports:
//   clk            in  1         : system clock
//   reset_n        in  1         : asynchronous active-low reset
//   req            in  N_REQ     : level requests
//   bcd_in         in  8*N_REQ   : per requester {tens, units}
//   gnt            out N_REQ     : one-hot, high while the job is in flight
//   done           out N_REQ     : one-cycle result-valid pulse
//   err            out N_REQ     : sticky range-error flags
//   bin_out        out 7*N_REQ   : latched per-requester results
//   busy           out 1         : sequencer not idle
//   conv_start     out 1         : one-cycle converter start
//   conv_bcd1/0    out 4 each    : tens/units digits to the converter
//   conv_ready     in  1         : converter idle
//   conv_done_tick in  1         : converter completion pulse
//   conv_bin       in  7         : converter result
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       bcd_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic [BIN_W*N_REQ-1:0]   bin_out,
  output logic                     busy,
  output logic                     conv_start,
  output logic [BCD_DIGIT_W-1:0]   conv_bcd1,
  output logic [BCD_DIGIT_W-1:0]   conv_bcd0,
  input  logic                     conv_ready,
  input  logic                     conv_done_tick,
  input  logic [BIN_W-1:0]         conv_bin
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       ptr;
  logic [N_REQ-1:0]       pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [BCD_DIGIT_W-1:0] sel_tens;
  logic [BCD_DIGIT_W-1:0] sel_units;
  logic                   sel_bad;
  logic                   capture;
  logic [N_REQ-1:0]       idx_onehot;
  logic [BIN_W*N_REQ-1:0] bin_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Digit mux for the requester the picker would grant this cycle.
  always_comb begin
    sel_tens  = '0;
    sel_units = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_tens  = bcd_in[8*i+4 +: 4];
        sel_units = bcd_in[8*i   +: 4];
      end
    end
  end

`ifdef BCD_ARB_RANGE_CHECK_EN
  assign sel_bad = !digit_ok(sel_tens) || !digit_ok(sel_units);
`else
  assign sel_bad = 1'b0;
`endif

  assign capture = (state == IDLE) && pick_valid && conv_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = sel_bad ? DONE : START;
      START:   state_nxt = WAIT;
      WAIT:    if (conv_done_tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job context: winner index, digits held stable for the converter, and the
  // round-robin pointer which moves past the requester just finished.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      ptr       <= '0;
      conv_bcd1 <= '0;
      conv_bcd0 <= '0;
    end else begin
      if (capture) begin
        idx       <= pick_idx;
        conv_bcd1 <= sel_tens;
        conv_bcd0 <= sel_units;
      end
      if (state == DONE) begin
        ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Only the granted requester's result slot is ever written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
    end else if (state == WAIT && conv_done_tick) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (idx == IDX_W'(i)) bin_q[BIN_W*i +: BIN_W] <= conv_bin;
      end
    end
  end

`ifdef BCD_ARB_RANGE_CHECK_EN
  logic [N_REQ-1:0] err_q;

  // A grant clears the requester's flag; a rejected capture sets it again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pick_grant[i]) err_q[i] <= sel_bad;
      end
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_onehot[i] = (idx == IDX_W'(i));
    end
  end

  assign gnt        = (state == START || state == WAIT) ? idx_onehot : '0;
  assign done       = (state == DONE) ? idx_onehot : '0;
  assign busy       = (state != IDLE);
  assign conv_start = (state == START);
  assign bin_out    = bin_q;

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one two-digit BCD-to-binary converter among `N_REQ` requesters (switch banks, keypad scanner, UART command parser). It captures a requester's two BCD digits and pulses the converter's `start`. It then waits for the converter's `done_tick` and writes the 7-bit result into that requester's result register with a one-cycle `done` pulse. It sits between the requesters and the single converter instance in each top-level synth wrapper.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `clk` in 1: system clock (100 MHz on board)
- `reset_n` in 1: asynchronous, active-low reset
- `req` in N_REQ: level request, one bit per requester
- `bcd_in` in 8*N_REQ: requester i digits at [8i+7:8i]; tens at [8i+7:8i+4], units at [8i+3:8i]
- `gnt` out N_REQ: one-hot; high from capture until the result is written
- `done` out N_REQ: one-cycle pulse when requester i's result is valid
- `err` out N_REQ: sticky per-requester range-error flag; cleared on the next grant to that requester
- `bin_out` out 7*N_REQ: latched result for requester i at [7i+6:7i]
- `busy` out 1: high whenever state is not IDLE
- `conv_start` out 1: one-cycle start to the converter
- `conv_bcd1`, `conv_bcd0` out 4 each: tens and units digits, held stable from start until done
- `conv_ready` in 1: converter idle
- `conv_done_tick` in 1: converter one-cycle completion
- `conv_bin` in 7: converter result, valid with `conv_done_tick`

## Operation
- States: IDLE, START, WAIT, DONE.
- **IDLE**
  - If `|req` and `conv_ready`, select the first set `req` bit at or after pointer `ptr`, wrapping modulo N_REQ.
  - Register the index and latch its digits into `conv_bcd1`/`conv_bcd0`.
  - Set `gnt[idx]`, clear `err[idx]`, go to START.
  - With `conv_ready`=0, stay in IDLE.
- **START**: assert `conv_start` for exactly this cycle, go to WAIT.
- **WAIT**: on `conv_done_tick`, load `bin_out[idx]` from `conv_bin`, go to DONE. Otherwise hold.
- **DONE**
  - Pulse `done[idx]`, drop `gnt`.
  - Set `ptr` = idx+1, wrapping N_REQ-1 to 0. Go to IDLE.
- Requests are level-sensitive. A requester still asserting `req` in IDLE after its `done` is serviced again in round-robin order.
- Dropping `req` after grant does not abort: the conversion completes, the result is written and `done` pulses.
- Result registers for non-granted requesters never change.
- Reset values:
  - state IDLE, `ptr`=0
  - `gnt`, `done`, `err`, `busy`, `conv_start` all 0
  - `bin_out` all 0, `conv_bcd1`/`conv_bcd0` 0
- Reset asserted mid-conversion returns to IDLE immediately. The converter must share `reset_n`.

## Timing
- Request seen in IDLE at edge k: `gnt` high after edge k, `conv_start` high for cycle k+1 only.
- `conv_done_tick` at cycle m: `bin_out` updated and `done` high for cycle m+1. `busy` low from cycle m+2.
- Back-to-back service: next grant no earlier than cycle m+2, so there is one idle cycle between jobs.
- Total latency = converter latency + 3 cycles.
- `done` is exactly one cycle wide. `gnt` is never high for two requesters at once.

## Configuration
- `BCD_ARB_RANGE_CHECK_EN` defined:
  - In IDLE, a granted requester with either digit > 9 skips START/WAIT and goes directly to DONE.
  - It sets `err[idx]`=1 and leaves `bin_out[idx]` unchanged. The converter is never started.
- `BCD_ARB_RANGE_CHECK_EN` undefined:
  - Digits pass to the converter unchecked and `err` is tied to 0.

## Structure
- Package `bcd_arb_pkg`:
  - state enum (IDLE/START/WAIT/DONE)
  - `BCD_DIGIT_W`=4, `BIN_W`=7, `BCD_MAX`=9
- Sub-module `rr_pick`: combinational round-robin priority selector. Inputs: req vector, ptr. Outputs: one-hot grant and index. Reusable for other shared IO resources such as UART TX and the seven-segment message buffer.

## Test plan
- Single request: N_REQ=4, req=4'b0100, digits 4'h4/4'h2 → `conv_start` pulse with bcd1=4, bcd0=2; `bin_out[2]`=7'd42; one `done[2]` pulse.
- Simultaneous requests: req=4'b1111 held → grant order 0,1,2,3,0. Each `done` precedes the next `gnt`, with no overlap.
- Pointer wrap: ptr=3 after servicing 2, req=4'b1001 → requester 3 first, then 0.
- `conv_ready` low: req asserted while `conv_ready`=0 for 10 cycles → no grant or start until `conv_ready` rises, then grant the next cycle.
- Reset mid-conversion: assert `reset_n`=0 in WAIT → all outputs return to reset values asynchronously. After release, req=4'b0001 is serviced from IDLE normally.
- Range check (macro on): digits 4'hA/4'h3 → no `conv_start`, `err[idx]`=1, `done` pulse, `bin_out` unchanged. Next valid request from the same requester clears `err`.
